// File: rtl/mips_alu_seq_if.sv
// Request/result bundle between the execute-stage control unit and mips_alu_seq.
interface mips_alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] T;
  logic [4:0]       FS;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Y_hi;
  logic [WIDTH-1:0] Y_lo;
  logic             N;
  logic             Z;
  logic             V;
  logic             C;

  modport master (output start, S, T, FS,
                  input  busy, done, Y_hi, Y_lo, N, Z, V, C);
  modport slave  (input  start, S, T, FS,
                  output busy, done, Y_hi, Y_lo, N, Z, V, C);
endinterface

// File: rtl/mips_alu_seq.sv
// Registered MIPS ALU: single-cycle arithmetic/logic ops plus iterative
// signed/unsigned multiply and divide producing a double-width result.
module mips_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mips_alu_seq_if.slave bus
);
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ALL_ONES    = '1;
  localparam logic [WIDTH-1:0] MOST_NEG    = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] SP_INIT_VAL = WIDTH'(10'h3FC);

  localparam logic [4:0] F_PASS_S = 5'h00, F_PASS_T = 5'h01, F_ADD  = 5'h02, F_ADDU = 5'h03,
                         F_SUB    = 5'h04, F_SUBU   = 5'h05, F_SLT  = 5'h06, F_SLTU = 5'h07,
                         F_AND    = 5'h08, F_OR     = 5'h09, F_XOR  = 5'h0A, F_NOR  = 5'h0B,
                         F_SRL    = 5'h0C, F_SRA    = 5'h0D, F_SLL  = 5'h0E, F_INC  = 5'h0F,
                         F_INC4   = 5'h10, F_DEC    = 5'h11, F_DEC4 = 5'h12, F_ZERO = 5'h13,
                         F_ONES   = 5'h14, F_SPINIT = 5'h15, F_ANDI = 5'h16, F_ORI  = 5'h17,
                         F_LUI    = 5'h18, F_XORI   = 5'h19, F_MUL  = 5'h1A, F_MULU = 5'h1B,
                         F_DIV    = 5'h1C, F_DIVU   = 5'h1D;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  logic             start;
  logic [WIDTH-1:0] s, t;
  logic [4:0]       fs;
  assign start = bus.start;
  assign s     = bus.S;
  assign t     = bus.T;
  assign fs    = bus.FS;

  // Immediate mask (low 16 bits), LUI value and the unused-code byte pattern.
  logic [WIDTH-1:0] imm_mask, lui_val, unused_pat;
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_imm
      if (gi < 16) begin : g_low
        assign imm_mask[gi] = 1'b1;
        assign lui_val[gi]  = 1'b0;
      end else begin : g_high
        assign imm_mask[gi] = 1'b0;
        assign lui_val[gi]  = t[gi-16];
      end
    end
    for (genvar gi = 0; gi < WIDTH / 8; gi++) begin : g_pat
      assign unused_pat[gi*8 +: 8] = 8'hF1;
    end
  endgenerate

  // Single-cycle result
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c, alu_v;

  always_comb begin
    wide  = '0;
    alu_y = unused_pat;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (fs)
      F_PASS_S: alu_y = s;
      F_PASS_T: alu_y = t;
      F_ADD, F_ADDU: begin
        wide  = {1'b0, s} + {1'b0, t};
        alu_y = wide[MSB:0];
        alu_c = wide[WIDTH];
        if (fs == F_ADD) alu_v = (s[MSB] == t[MSB]) && (alu_y[MSB] != s[MSB]);
      end
      F_SUB, F_SUBU: begin
        wide  = {1'b0, s} - {1'b0, t};
        alu_y = wide[MSB:0];
        alu_c = wide[WIDTH];
        if (fs == F_SUB) alu_v = (s[MSB] != t[MSB]) && (alu_y[MSB] != s[MSB]);
      end
      F_SLT:  alu_y = {{(WIDTH-1){1'b0}}, $signed(s) < $signed(t)};
      F_SLTU: alu_y = {{(WIDTH-1){1'b0}}, s < t};
      F_AND:  alu_y = s & t;
      F_OR:   alu_y = s | t;
      F_XOR:  alu_y = s ^ t;
      F_NOR:  alu_y = ~(s | t);
      F_SRL: begin alu_y = {1'b0, t[MSB:1]};    alu_c = t[0];   end
      F_SRA: begin alu_y = {t[MSB], t[MSB:1]};  alu_c = t[0];   end
      F_SLL: begin alu_y = {t[MSB-1:0], 1'b0};  alu_c = t[MSB]; end
      F_INC, F_INC4: begin
        wide  = {1'b0, s} + ((fs == F_INC) ? (WIDTH+1)'(1) : (WIDTH+1)'(4));
        alu_y = wide[MSB:0];
        alu_c = wide[WIDTH];
      end
      F_DEC, F_DEC4: begin
        wide  = {1'b0, s} - ((fs == F_DEC) ? (WIDTH+1)'(1) : (WIDTH+1)'(4));
        alu_y = wide[MSB:0];
        alu_c = wide[WIDTH];
      end
      F_ZERO:   alu_y = '0;
      F_ONES:   alu_y = ALL_ONES;
      F_SPINIT: alu_y = SP_INIT_VAL;
      F_ANDI:   alu_y = s & (t & imm_mask);
      F_ORI:    alu_y = s | (t & imm_mask);
      F_LUI:    alu_y = lui_val;
      F_XORI:   alu_y = s ^ (t & imm_mask);
      default:  alu_y = unused_pat;
    endcase
  end

  // Iterative datapath: hi holds partial product / remainder, lo the multiplier / quotient.
  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH:0]   hi_reg, hi_next;
  logic [WIDTH-1:0] lo_reg, lo_next, b_reg, b_next;
  logic             div_reg, div_next, neg_q_reg, neg_q_next, neg_r_reg, neg_r_next;
  logic             dz_reg, dz_next, ovf_reg, ovf_next;
  logic             busy_reg, busy_next, done_reg, done_next;
  logic [WIDTH-1:0] y_hi_reg, y_hi_next, y_lo_reg, y_lo_next;
  logic             n_reg, n_next, z_reg, z_next, v_reg, v_next, c_reg, c_next;

  logic             is_multi, is_div_op, signed_op, s_neg, t_neg;
  logic [WIDTH-1:0] s_mag, t_mag;
  assign is_multi  = (fs == F_MUL) || (fs == F_MULU) || (fs == F_DIV) || (fs == F_DIVU);
  assign is_div_op = (fs == F_DIV) || (fs == F_DIVU);
  assign signed_op = (fs == F_MUL) || (fs == F_DIV);
  assign s_neg     = signed_op & s[MSB];
  assign t_neg     = signed_op & t[MSB];
  assign s_mag     = s_neg ? -s : s;
  assign t_mag     = t_neg ? -t : t;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               div_ge;
  assign mul_sum   = hi_reg + {1'b0, (lo_reg[0] ? b_reg : '0)};
  assign div_shift = {hi_reg[MSB:0], lo_reg[MSB]};
  assign div_ge    = (div_shift >= {1'b0, b_reg});
  assign div_diff  = div_shift - {1'b0, b_reg};

  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;
  assign prod_mag = {hi_reg[MSB:0], lo_reg};
  assign prod_fix = neg_q_reg ? -prod_mag : prod_mag;
  // A zero divisor leaves the quotient all ones and the dividend in the remainder.
  assign q_fix    = dz_reg ? ALL_ONES : (neg_q_reg ? -lo_reg : lo_reg);
  assign r_fix    = neg_r_reg ? -hi_reg[MSB:0] : hi_reg[MSB:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    b_next     = b_reg;
    div_next   = div_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    dz_next    = dz_reg;
    ovf_next   = ovf_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    y_hi_next  = y_hi_reg;
    y_lo_next  = y_lo_reg;
    n_next     = n_reg;
    z_next     = z_reg;
    v_next     = v_reg;
    c_next     = c_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (is_multi) begin
            state_next = CALC;
            cnt_next   = '0;
            hi_next    = '0;
            lo_next    = s_mag;
            b_next     = t_mag;
            div_next   = is_div_op;
            neg_q_next = s_neg ^ t_neg;
            neg_r_next = s_neg;
            dz_next    = is_div_op && (t == '0);
            ovf_next   = (fs == F_DIV) && (s == MOST_NEG) && (t == ALL_ONES);
            busy_next  = 1'b1;
          end else begin
            y_hi_next = '0;
            y_lo_next = alu_y;
            n_next    = alu_y[MSB];
            z_next    = (alu_y == '0);
            v_next    = alu_v;
            c_next    = alu_c;
            done_next = 1'b1;
          end
        end
      end
      CALC: begin
        if (div_reg) begin
          hi_next = div_ge ? div_diff : div_shift;
          lo_next = {lo_reg[MSB-1:0], div_ge};
        end else begin
          hi_next = {1'b0, mul_sum[WIDTH:1]};
          lo_next = {mul_sum[0], lo_reg[MSB:1]};
        end
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CNT_LAST) state_next = FIX;
      end
      FIX: begin
        if (div_reg) begin
          y_hi_next = r_fix;
          y_lo_next = q_fix;
          n_next    = q_fix[MSB];
          z_next    = (q_fix == '0);
          v_next    = dz_reg | ovf_reg;
        end else begin
          y_hi_next = prod_fix[2*WIDTH-1:WIDTH];
          y_lo_next = prod_fix[MSB:0];
          n_next    = prod_fix[2*WIDTH-1];
          z_next    = (prod_fix == '0);
          v_next    = 1'b0;
        end
        c_next     = 1'b0;
        done_next  = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      b_reg     <= '0;
      div_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      dz_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      y_hi_reg  <= '0;
      y_lo_reg  <= '0;
      n_reg     <= 1'b0;
      z_reg     <= 1'b0;
      v_reg     <= 1'b0;
      c_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      b_reg     <= b_next;
      div_reg   <= div_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      dz_reg    <= dz_next;
      ovf_reg   <= ovf_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      y_hi_reg  <= y_hi_next;
      y_lo_reg  <= y_lo_next;
      n_reg     <= n_next;
      z_reg     <= z_next;
      v_reg     <= v_next;
      c_reg     <= c_next;
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.Y_hi = y_hi_reg;
  assign bus.Y_lo = y_lo_reg;
  assign bus.N    = n_reg;
  assign bus.Z    = z_reg;
  assign bus.V    = v_reg;
  assign bus.C    = c_reg;
endmodule

// File: tb/tb_mips_alu_seq.sv
// Randomised bench for mips_alu_seq (WIDTH=32) against an arithmetic reference model,
// plus a few directed checks on a WIDTH=8 instance.
`timescale 1ns/1ps
module tb_mips_alu_seq;
  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_alu_seq_if #(.WIDTH(W)) bus ();
  mips_alu_seq_if #(.WIDTH(8)) bus8 ();
  mips_alu_seq #(.WIDTH(W)) dut  (.clk(clk), .reset(reset), .bus(bus));
  mips_alu_seq #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        n, z, v, c;
  } res_t;

  typedef struct {
    int          k;
    int          due;
    bit          multi;
    logic [4:0]  fs;
    logic [31:0] s, t;
    res_t        r;
  } txn_t;

  txn_t pend[$];
  res_t last_exp = '0;
  int   ecnt = 0;
  int   free_edge = 0;
  int   checks = 0;
  int   failures = 0;
  bit   chk_en = 1'b0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, ecnt);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operand values.
  function automatic res_t model(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    res_t r;
    longint ss, st, sr;
    longint unsigned us, ut, ur;
    logic [63:0] wide;
    logic [31:0] imm;
    bit is_mul;
    r = '0;
    ss = longint'($signed(s));
    st = longint'($signed(t));
    us = {32'h0, s};
    ut = {32'h0, t};
    imm = {16'h0, t[15:0]};
    is_mul = 1'b0;
    case (fs)
      5'h00: r.lo = s;
      5'h01: r.lo = t;
      5'h02, 5'h03: begin
        ur = us + ut; r.lo = ur[31:0]; r.c = (ur > 64'hFFFFFFFF);
        if (fs == 5'h02) begin sr = ss + st; r.v = (sr > SMAX) || (sr < SMIN); end
      end
      5'h04, 5'h05: begin
        r.lo = s - t; r.c = (s < t);
        if (fs == 5'h04) begin sr = ss - st; r.v = (sr > SMAX) || (sr < SMIN); end
      end
      5'h06: r.lo = (ss < st) ? 32'd1 : 32'd0;
      5'h07: r.lo = (s < t) ? 32'd1 : 32'd0;
      5'h08: r.lo = s & t;
      5'h09: r.lo = s | t;
      5'h0A: r.lo = s ^ t;
      5'h0B: r.lo = ~(s | t);
      5'h0C: begin r.lo = t >> 1; r.c = t[0]; end
      5'h0D: begin sr = st >>> 1; r.lo = sr[31:0]; r.c = t[0]; end
      5'h0E: begin r.lo = t << 1; r.c = t[31]; end
      5'h0F: begin ur = us + 1; r.lo = ur[31:0]; r.c = (ur > 64'hFFFFFFFF); end
      5'h10: begin ur = us + 4; r.lo = ur[31:0]; r.c = (ur > 64'hFFFFFFFF); end
      5'h11: begin r.lo = s - 32'd1; r.c = (s < 32'd1); end
      5'h12: begin r.lo = s - 32'd4; r.c = (s < 32'd4); end
      5'h13: r.lo = 32'h0;
      5'h14: r.lo = 32'hFFFFFFFF;
      5'h15: r.lo = 32'h3FC;
      5'h16: r.lo = s & imm;
      5'h17: r.lo = s | imm;
      5'h18: r.lo = {t[15:0], 16'h0};
      5'h19: r.lo = s ^ imm;
      5'h1A: begin sr = ss * st; wide = sr; r.hi = wide[63:32]; r.lo = wide[31:0]; is_mul = 1'b1; end
      5'h1B: begin ur = us * ut; wide = ur; r.hi = wide[63:32]; r.lo = wide[31:0]; is_mul = 1'b1; end
      5'h1C: begin
        if (t == 32'h0) begin r.lo = 32'hFFFFFFFF; r.hi = s; r.v = 1'b1; end
        else if (s == 32'h80000000 && t == 32'hFFFFFFFF) begin r.lo = 32'h80000000; r.hi = 32'h0; r.v = 1'b1; end
        else begin sr = ss / st; r.lo = sr[31:0]; sr = ss % st; r.hi = sr[31:0]; end
      end
      5'h1D: begin
        if (t == 32'h0) begin r.lo = 32'hFFFFFFFF; r.hi = s; r.v = 1'b1; end
        else begin r.lo = s / t; r.hi = s % t; end
      end
      default: r.lo = 32'hF1F1F1F1;
    endcase
    if (is_mul) begin r.n = r.hi[31]; r.z = ({r.hi, r.lo} == 64'h0); end
    else        begin r.n = r.lo[31]; r.z = (r.lo == 32'h0); end
    return r;
  endfunction

  // Compare process: done, busy and held outputs on every cycle out of reset.
  always @(negedge clk) begin : cmp
    bit exp_done, exp_busy;
    if (!reset && chk_en) begin
      exp_done = 1'b0;
      exp_busy = 1'b0;
      foreach (pend[i])
        if (pend[i].multi && ecnt >= pend[i].k && ecnt < pend[i].due) exp_busy = 1'b1;
      if (pend.size() > 0 && pend[0].due == ecnt) begin
        exp_done = 1'b1;
        last_exp = pend[0].r;
        $display("txn fs=%h s=%h t=%h -> hi=%h lo=%h nzvc=%b%b%b%b", pend[0].fs, pend[0].s, pend[0].t,
                 pend[0].r.hi, pend[0].r.lo, pend[0].r.n, pend[0].r.z, pend[0].r.v, pend[0].r.c);
        void'(pend.pop_front());
      end
      check("done", 72'(bus.done), 72'(exp_done));
      check("busy", 72'(bus.busy), 72'(exp_busy));
      check("outputs", 72'({bus.Y_hi, bus.Y_lo, bus.N, bus.Z, bus.V, bus.C}), 72'(last_exp));
    end
  end

  // Called at a negedge: drives a request for the next edge and records it if accepted.
  task automatic request(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    txn_t x;
    int k;
    k = ecnt + 1;
    bus.start = 1'b1; bus.FS = fs; bus.S = s; bus.T = t;
    if (k >= free_edge) begin
      x.k = k; x.fs = fs; x.s = s; x.t = t;
      x.multi = (fs >= 5'h1A && fs <= 5'h1D);
      x.due = x.multi ? k + W + 1 : k;
      x.r = model(fs, s, t);
      pend.push_back(x);
      free_edge = x.due + 1;
    end
  endtask

  task automatic run(input logic [4:0] fs, input logic [31:0] s, input logic [31:0] t);
    @(negedge clk);
    while (ecnt + 1 < free_edge) @(negedge clk);
    request(fs, s, t);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run8(input string name, input logic [4:0] fs, input logic [7:0] s, input logic [7:0] t,
                      input logic [7:0] ehi, input logic [7:0] elo, input int elat);
    int k, guard;
    @(negedge clk);
    bus8.start = 1'b1; bus8.FS = fs; bus8.S = s; bus8.T = t;
    k = ecnt + 1;
    @(negedge clk);
    bus8.start = 1'b0;
    guard = 0;
    while (!bus8.done && guard < 40) begin @(negedge clk); guard++; end
    check({name, "_latency"}, 72'(ecnt - k), 72'(elat));
    check({name, "_hi"}, 72'(bus8.Y_hi), 72'(ehi));
    check({name, "_lo"}, 72'(bus8.Y_lo), 72'(elo));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [4:0] rand_fs();
    if ($urandom_range(0, 3) == 0) return 5'h1A + 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int guard;
    bus.start = 1'b0;  bus.S = '0;  bus.T = '0;  bus.FS = '0;
    bus8.start = 1'b0; bus8.S = '0; bus8.T = '0; bus8.FS = '0;

    // Hand-computed values that pin the model
    check("pin_add",   72'(model(5'h02, 32'h7FFFFFFF, 32'h1)),        {4'h0, 32'h0, 32'h80000000, 4'b1010});
    check("pin_subu",  72'(model(5'h05, 32'h0, 32'h1)),               {4'h0, 32'h0, 32'hFFFFFFFF, 4'b1001});
    check("pin_sra",   72'(model(5'h0D, 32'h0, 32'h80000001)),        {4'h0, 32'h0, 32'hC0000000, 4'b1001});
    check("pin_mul",   72'(model(5'h1A, 32'hFFFFFFFD, 32'h7)),        {4'h0, 32'hFFFFFFFF, 32'hFFFFFFEB, 4'b1000});
    check("pin_mulu",  72'(model(5'h1B, 32'hFFFFFFFF, 32'hFFFFFFFF)), {4'h0, 32'hFFFFFFFE, 32'h00000001, 4'b1000});
    check("pin_divu",  72'(model(5'h1D, 32'd100, 32'd7)),             {4'h0, 32'd2, 32'd14, 4'b0000});
    check("pin_div",   72'(model(5'h1C, 32'hFFFFFFF9, 32'h2)),        {4'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 4'b1000});
    check("pin_div0",  72'(model(5'h1C, 32'h5, 32'h0)),               {4'h0, 32'h5, 32'hFFFFFFFF, 4'b1010});
    check("pin_divmn", 72'(model(5'h1C, 32'h80000000, 32'hFFFFFFFF)), {4'h0, 32'h0, 32'h80000000, 4'b1010});

    repeat (3) @(negedge clk);
    check("reset_busy", 72'(bus.busy), 72'(0));
    check("reset_done", 72'(bus.done), 72'(0));
    check("reset_outputs", 72'({bus.Y_hi, bus.Y_lo, bus.N, bus.Z, bus.V, bus.C}), 72'(0));
    check("reset_outputs8", 72'({bus8.busy, bus8.done, bus8.Y_hi, bus8.Y_lo, bus8.N, bus8.Z, bus8.V, bus8.C}), 72'(0));
    reset = 1'b0;
    last_exp = '0;
    free_edge = 0;
    chk_en = 1'b1;

    run(5'h02, 32'h7FFFFFFF, 32'h1);
    run(5'h05, 32'h0, 32'h1);
    run(5'h0D, 32'h0, 32'h80000001);
    run(5'h1A, 32'hFFFFFFFD, 32'h7);
    run(5'h1B, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run(5'h1D, 32'd100, 32'd7);
    run(5'h1C, 32'hFFFFFFF9, 32'h2);
    run(5'h1C, 32'h5, 32'h0);
    run(5'h1C, 32'h80000000, 32'hFFFFFFFF);
    run(5'h1F, 32'h12345678, 32'h9);

    // In-flight MUL, ignored start while busy, then asynchronous reset mid-operation
    run(5'h1A, 32'hFFFFFFFD, 32'h7);
    repeat (4) @(negedge clk);
    request(5'h02, 32'h1, 32'h2);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    pend.delete();
    last_exp = '0;
    #1;
    check("midreset_busy", 72'(bus.busy), 72'(0));
    check("midreset_done", 72'(bus.done), 72'(0));
    check("midreset_outputs", 72'({bus.Y_hi, bus.Y_lo, bus.N, bus.Z, bus.V, bus.C}), 72'(0));
    @(negedge clk);
    reset = 1'b0;
    free_edge = 0;
    run(5'h03, 32'd2, 32'd3);

    run8("w8_mulu", 5'h1B, 8'hFF, 8'hFF, 8'hFE, 8'h01, 9);
    run8("w8_unused", 5'h1F, 8'h12, 8'h34, 8'h00, 8'hF1, 0);

    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 2) != 0) request(rand_fs(), pick(), pick());
      else begin
        bus.start = 1'b0;
        bus.FS = rand_fs();
        bus.S = $urandom;
        bus.T = $urandom;
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (pend.size() > 0 && guard < 100) begin @(negedge clk); guard++; end
    check("drain", 72'(pend.size()), 72'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
